alu_div_16bit: RTL

ALU_DIV_16BIT -- requirements
Module: alu_div_16bit

---
 rtl/alu_div_16bit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_div_16bit.sv
//==============================================================================
// alu_div_16bit : 16-bit restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the signed_op port and two's-complement support.
// Revision: 1.0
//==============================================================================
`default_nettype none

module alu_div_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        ovfl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_dvd;
    logic [15:0] r_dvs;
    logic [15:0] r_q;
    logic [15:0] r_rem;
    logic [3:0]  r_cnt;
    logic        r_fin;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;
    logic        r_ovfl;
    logic [15:0] r_quo_o;
    logic [15:0] r_rem_o;

    logic [15:0] w_mag_a;
    logic [15:0] w_mag_b;
    logic [15:0] w_q_fin;
    logic [15:0] w_r_fin;
    logic        w_ovf_cap;
    logic [16:0] w_sh;
    logic [16:0] w_diff;
    logic        w_ge;

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic r_ovf_c;
    logic w_sgn_a;
    logic w_sgn_b;

    assign w_sgn_a   = signed_op & dividend[15];
    assign w_sgn_b   = signed_op & divisor[15];
    assign w_mag_a   = w_sgn_a ? (16'd0 - dividend) : dividend;
    assign w_mag_b   = w_sgn_b ? (16'd0 - divisor)  : divisor;
    // Only -32768 / -1 overflows; its magnitude quotient 16'h8000 is already the wrapped answer.
    assign w_ovf_cap = signed_op & (dividend == 16'h8000) & (divisor == 16'hFFFF);
    assign w_q_fin   = r_neg_q ? (16'd0 - r_q)   : r_q;
    assign w_r_fin   = r_neg_r ? (16'd0 - r_rem) : r_rem;
`else
    assign w_mag_a   = dividend;
    assign w_mag_b   = divisor;
    assign w_ovf_cap = 1'b0;
    assign w_q_fin   = r_q;
    assign w_r_fin   = r_rem;
`endif

    // Partial remainder shifted left with the next dividend bit; bit 16 of the difference is the borrow.
    assign w_sh   = {r_rem, r_q[15]};
    assign w_diff = w_sh - {1'b0, r_dvs};
    assign w_ge   = ~w_diff[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dvd   <= 16'd0;
            r_dvs   <= 16'd0;
            r_q     <= 16'd0;
            r_rem   <= 16'd0;
            r_cnt   <= 4'd0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_ovfl  <= 1'b0;
            r_quo_o <= 16'd0;
            r_rem_o <= 16'd0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ovf_c <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= w_mag_b;
                        r_q     <= w_mag_a;
                        r_rem   <= 16'd0;
                        r_cnt   <= 4'd0;
                        r_fin   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`ifdef DIV_SIGNED_EN
                        r_neg_q <= w_sgn_a ^ w_sgn_b;
                        r_neg_r <= w_sgn_a;
                        r_ovf_c <= w_ovf_cap;
`endif
                    end
                end
                S_RUN: begin
                    if (r_dvs == 16'd0) begin
                        // Zero divisor bypasses the shift-subtract steps entirely.
                        r_quo_o <= 16'hFFFF;
                        r_rem_o <= r_dvd;
                        r_dz    <= 1'b1;
                        r_ovfl  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!r_fin) begin
                        r_q   <= {r_q[14:0], w_ge};
                        r_rem <= w_ge ? w_diff[15:0] : w_sh[15:0];
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_fin <= 1'b1;
                        end
                    end else begin
                        r_quo_o <= w_q_fin;
                        r_rem_o <= w_r_fin;
                        r_dz    <= 1'b0;
`ifdef DIV_SIGNED_EN
                        r_ovfl  <= r_ovf_c;
`else
                        r_ovfl  <= 1'b0;
`endif
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef DIV_SIGNED_EN
    logic w_unused;
    assign w_unused = w_ovf_cap;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo_o;
    assign remainder   = r_rem_o;
    assign div_by_zero = r_dz;
`ifdef DIV_SIGNED_EN
    assign ovfl        = r_ovfl;
`else
    assign ovfl        = 1'b0;
`endif

endmodule

`default_nettype wire
